// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute stage: widths, ALU operation codes,
// R-type funct codes, destination-register selects and the EX/MEM record.
package mips_pkg;

  localparam int DW = 32;  // datapath width
  localparam int RW = 5;   // register-index width

  // Link register written by jal/jalr.
  localparam logic [RW-1:0] RA_REG = 5'd31;

  // ALU operation codes carried in ALUOp from decode.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_RTYPE = 4'd15
  } alu_op_e;

  // R-type funct field values (IR[5:0]).
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;

  // Destination-register select; both upper encodings pick the link register.
  typedef enum logic [1:0] {
    REGDST_RT     = 2'd0,
    REGDST_RD     = 2'd1,
    REGDST_RA     = 2'd2,
    REGDST_RA_ALT = 2'd3
  } reg_dst_e;

  // Contents of the EX/MEM pipeline register.
  typedef struct packed {
    logic [DW-1:0] alu_out;
    logic [DW-1:0] store_data;
    logic [DW-1:0] pc_plus_4;
    logic [RW-1:0] write_reg;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_to_reg;
  } ex_mem_t;

  // Resolve the ALUOp field (and funct, for R-type) into a concrete ALU
  // operation. Unlisted ALUOp codes and unknown funct values fall back to ADD.
  function automatic alu_op_e decode_alu_op(input logic [3:0] alu_op_code,
                                            input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    if (alu_op_code == ALU_RTYPE) begin
      case (funct)
        FN_ADD, FN_ADDU: op = ALU_ADD;
        FN_SUB, FN_SUBU: op = ALU_SUB;
        FN_AND:          op = ALU_AND;
        FN_OR:           op = ALU_OR;
        FN_XOR:          op = ALU_XOR;
        FN_NOR:          op = ALU_NOR;
        FN_SLT:          op = ALU_SLT;
        FN_SLTU:         op = ALU_SLTU;
        FN_SLL:          op = ALU_SLL;
        FN_SRL:          op = ALU_SRL;
        FN_SRA:          op = ALU_SRA;
        default:         op = ALU_ADD;
      endcase
    end else if (alu_op_code <= ALU_SRA) begin
      op = alu_op_e'(alu_op_code);
    end
    return op;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage. Shifts move operand b by a[4:0];
// add and subtract wrap modulo 2^DW with no overflow detection.
module alu
  import mips_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_e       op,
  output logic [DW-1:0] result,
  output logic          zero
);

  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] sh_amt;

  assign sh_amt = a[SHW-1:0];

  // Select the operation result.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    result = a + b;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DW-1){1'b0}}, (a < b)};
      ALU_SLL:  result = b << sh_amt;
      ALU_SRL:  result = b >> sh_amt;
      ALU_SRA:  result = $signed(b) >>> sh_amt;
      default:  result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select, branch
// resolution and the EX/MEM pipeline register feeding the MEM stage.
module ex_stage
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          EX_MEM_stall,
  input  logic          EX_MEM_flush,
  input  logic [31:0]   IR_in,
  input  logic [DW-1:0] PC_plus_4_in,
  input  logic [DW-1:0] LU_out_in,
  input  logic [DW-1:0] RegA_in,
  input  logic [DW-1:0] RegB_in,
  input  logic          Branch_in,
  input  logic          RegWrite_in,
  input  logic          MemRead_in,
  input  logic          MemWrite_in,
  input  logic          ALUSrc1_in,
  input  logic          ALUSrc2_in,
  input  logic [1:0]    RegDst_in,
  input  logic [1:0]    MemtoReg_in,
  input  logic [3:0]    ALUOp_in,
  input  logic          MEM_WB_RegWrite,
  input  logic [RW-1:0] MEM_WB_WriteReg,
  input  logic [DW-1:0] MEM_WB_WriteData,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target,
  output logic          IF_ID_flush_req,
  output logic          ID_EX_flush_req,
  output logic [DW-1:0] ALU_out_EX_MEM_out,
  output logic [DW-1:0] StoreData_EX_MEM_out,
  output logic [DW-1:0] PC_plus_4_EX_MEM_out,
  output logic [RW-1:0] WriteReg_EX_MEM_out,
  output logic          RegWrite_EX_MEM_out,
  output logic          MemRead_EX_MEM_out,
  output logic          MemWrite_EX_MEM_out,
  output logic [1:0]    MemtoReg_EX_MEM_out
);

  // Instruction fields.
  logic [RW-1:0] rs_idx;
  logic [RW-1:0] rt_idx;
  logic [RW-1:0] rd_idx;
  logic [4:0]    shamt;
  logic [5:0]    funct;
  logic          is_bne;

  assign rs_idx = IR_in[25:21];
  assign rt_idx = IR_in[20:16];
  assign rd_idx = IR_in[15:11];
  assign shamt  = IR_in[10:6];
  assign funct  = IR_in[5:0];
  assign is_bne = IR_in[26];

  // Opcode bits above IR[26] are fully decoded upstream.
  logic unused_ir_bits;
  assign unused_ir_bits = ^IR_in[31:27];

  ex_mem_t       ex_mem_q;
  ex_mem_t       ex_mem_d;
  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_result;
  logic          alu_zero;
  alu_op_e       alu_op;
  logic [RW-1:0] write_reg;
  logic          ex_mem_hit_rs;
  logic          ex_mem_hit_rt;
  logic          mem_wb_hit_rs;
  logic          mem_wb_hit_rt;

  // A pending write matches a source only when it targets a nonzero register;
  // $0 is hardwired and must never be forwarded.
  assign ex_mem_hit_rs = ex_mem_q.reg_write && (ex_mem_q.write_reg != '0) &&
                         (ex_mem_q.write_reg == rs_idx);
  assign ex_mem_hit_rt = ex_mem_q.reg_write && (ex_mem_q.write_reg != '0) &&
                         (ex_mem_q.write_reg == rt_idx);
  assign mem_wb_hit_rs = MEM_WB_RegWrite && (MEM_WB_WriteReg != '0) &&
                         (MEM_WB_WriteReg == rs_idx);
  assign mem_wb_hit_rt = MEM_WB_RegWrite && (MEM_WB_WriteReg != '0) &&
                         (MEM_WB_WriteReg == rt_idx);

  // Forwarding muxes: the younger EX/MEM result wins over MEM/WB.
  always_comb begin
    fwd_rs = RegA_in;
    if (ex_mem_hit_rs)      fwd_rs = ex_mem_q.alu_out;
    else if (mem_wb_hit_rs) fwd_rs = MEM_WB_WriteData;

    fwd_rt = RegB_in;
    if (ex_mem_hit_rt)      fwd_rt = ex_mem_q.alu_out;
    else if (mem_wb_hit_rt) fwd_rt = MEM_WB_WriteData;
  end

  // ALU operand selection and operation decode.
  always_comb begin
    op_a   = ALUSrc1_in ? {{(DW-5){1'b0}}, shamt} : fwd_rs;
    op_b   = ALUSrc2_in ? LU_out_in : fwd_rt;
    alu_op = decode_alu_op(ALUOp_in, funct);
  end

  alu u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Destination register: rt for I-type, rd for R-type, link register for jal/jalr.
  always_comb begin
    write_reg = RA_REG;
    case (reg_dst_e'(RegDst_in))
      REGDST_RT: write_reg = rt_idx;
      REGDST_RD: write_reg = rd_idx;
      default:   write_reg = RA_REG;
    endcase
  end

  // Branch resolution. A stalled branch is suppressed and resolves again once
  // the stall drops, so a redirect is never issued twice for one instruction.
  assign branch_taken    = Branch_in & (alu_zero ^ is_bne) & ~EX_MEM_stall;
  assign branch_target   = PC_plus_4_in + (LU_out_in << 2);
  assign IF_ID_flush_req = branch_taken;
  assign ID_EX_flush_req = branch_taken;

  // Next EX/MEM contents: flush inserts a bubble, stall holds, otherwise load.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (EX_MEM_flush) begin
      ex_mem_d = '0;
    end else if (!EX_MEM_stall) begin
      ex_mem_d.alu_out    = alu_result;
      ex_mem_d.store_data = fwd_rt;
      ex_mem_d.pc_plus_4  = PC_plus_4_in;
      ex_mem_d.write_reg  = write_reg;
      ex_mem_d.reg_write  = RegWrite_in;
      ex_mem_d.mem_read   = MemRead_in;
      ex_mem_d.mem_write  = MemWrite_in;
      ex_mem_d.mem_to_reg = MemtoReg_in;
    end
  end

  // EX/MEM pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values and
    // simulation matches the synthesized register behaviour.
    if (reset) ex_mem_q <= '0;
    else       ex_mem_q <= ex_mem_d;
  end

  assign ALU_out_EX_MEM_out   = ex_mem_q.alu_out;
  assign StoreData_EX_MEM_out = ex_mem_q.store_data;
  assign PC_plus_4_EX_MEM_out = ex_mem_q.pc_plus_4;
  assign WriteReg_EX_MEM_out  = ex_mem_q.write_reg;
  assign RegWrite_EX_MEM_out  = ex_mem_q.reg_write;
  assign MemRead_EX_MEM_out   = ex_mem_q.mem_read;
  assign MemWrite_EX_MEM_out  = ex_mem_q.mem_write;
  assign MemtoReg_EX_MEM_out  = ex_mem_q.mem_to_reg;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX register outputs and performs operand forwarding, ALU operation, destination-register selection and branch resolution. It owns the EX/MEM pipeline register that feeds the MEM stage. It also returns the branch redirect (taken + target) to IF/ID and the flush requests to IF/ID and ID/EX.

Parameters:
DW, 32, datapath width
RW, 5, register-index width
RA_REG, 31, link register index for jal/jalr

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
EX_MEM_stall  in  1  hold EX/MEM register (MEM not ready)
EX_MEM_flush  in  1  load bubble into EX/MEM
IR_in  in  32  instruction from ID/EX
PC_plus_4_in  in  32  PC+4 from ID/EX
LU_out_in  in  32  extended/LUI immediate from ID/EX
RegA_in, RegB_in  in  32  register read data from ID/EX
Branch_in, RegWrite_in, MemRead_in, MemWrite_in, ALUSrc1_in, ALUSrc2_in  in  1  controls from ID/EX
RegDst_in, MemtoReg_in  in  2  controls from ID/EX
ALUOp_in  in  4  ALU operation from ID/EX
MEM_WB_RegWrite  in  1  WB-stage write enable
MEM_WB_WriteReg  in  5  WB-stage destination
MEM_WB_WriteData  in  32  WB-stage result
branch_taken  out  1  combinational redirect request
branch_target  out  32  combinational redirect address
IF_ID_flush_req, ID_EX_flush_req  out  1  equal to branch_taken
ALU_out_EX_MEM_out, StoreData_EX_MEM_out, PC_plus_4_EX_MEM_out  out  32  registered
WriteReg_EX_MEM_out  out  5  registered
RegWrite_EX_MEM_out, MemRead_EX_MEM_out, MemWrite_EX_MEM_out  out  1  registered
MemtoReg_EX_MEM_out  out  2  registered

Behaviour:
- Register priority, evaluated at posedge clk: reset > EX_MEM_flush > EX_MEM_stall > load.
- Reset and flush both clear every registered output to 0.
- Stall holds all registered outputs.
- Load captures the new values. Latency is 1 cycle from ID/EX inputs to EX/MEM outputs.
- Forwarding for source rs (IR[25:21]) and rt (IR[20:16]):
  - 1st priority: registered EX/MEM output when RegWrite_EX_MEM_out is 1, WriteReg_EX_MEM_out is nonzero and equal to the source index → ALU_out_EX_MEM_out.
  - 2nd priority: MEM/WB, same conditions → MEM_WB_WriteData.
  - Otherwise: RegA_in / RegB_in.
  - Index 0 is never forwarded.
  - Load-use is guaranteed by an upstream bubble, so the EX/MEM path never forwards a load result.
- Operand A: ALUSrc1 = 1 gives zero-extended IR[10:6] (shamt); otherwise forwarded rs.
- Operand B: ALUSrc2 = 1 gives LU_out_in; otherwise forwarded rt.
- StoreData always takes forwarded rt.
- ALUOp codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA.
  - 15 means R-type: the operation is decoded from funct IR[5:0].
  - Unlisted codes perform ADD.
  - Shifts use B shifted by A[4:0].
  - Add and subtract are 32-bit modulo; no overflow trap.
- zero = (ALU result == 0).
- Destination register from RegDst:
  - 0 → rt.
  - 1 → rd (IR[15:11]).
  - 2 or 3 → RA_REG.
- Branch:
  - branch_taken = Branch_in & (zero XOR IR[26]), where IR[26] = 0 is beq and 1 is bne. Branch instructions use ALUOp SUB.
  - branch_target = PC_plus_4_in + (LU_out_in << 2), computed modulo 2^32.
  - When EX_MEM_stall = 1, branch_taken is forced to 0. The instruction re-resolves when the stall releases.
  - Taken branches still load normally; their RegWrite and MemWrite are 0 from decode.
- All combinational outputs depend only on current inputs and registered state. No combinational path exists from EX_MEM_flush to branch_taken.

Decomposition:
- Package mips_pkg holds:
  - ALUOp codes
  - funct codes (ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLTU 0x2B, SLL 0x00, SRL 0x02, SRA 0x03)
  - RegDst encodings
  - RA_REG
- One sub-module, alu (combinational; inputs A, B, op; outputs result, zero). The stage instantiates it once.

Test Plan:
- Reset held 2 cycles with arbitrary inputs → all EX/MEM outputs 0 and branch_taken 0. Release reset, apply add $3,$1,$2 with RegA=5, RegB=7 → next cycle ALU_out=12, WriteReg=3, RegWrite=1.
- Back-to-back: add $3 (result 12), then sub $4,$3,$1 with RegA_in stale=0, RegB=5 → EX/MEM forward gives ALU_out=7. Same case with MEM_WB also writing $3=99 → EX/MEM still wins, result 7.
- Write to $0 pending in EX/MEM and MEM/WB (value 0xDEAD) while the next instruction reads $0 with RegA=0 → no forwarding, operand 0.
- beq with RegA=RegB=4, PC_plus_4=0x100, LU_out=0xFFFFFFFE → branch_taken=1, target=0xF8, both flush_req=1. Same with bne → taken 0.
- EX_MEM_stall asserted 3 cycles → outputs unchanged and branch_taken 0. Assert flush and stall together → outputs cleared.
- sra with shamt 4 on B=0x80000000 → 0xF8000000. sltu 1 vs 0xFFFFFFFF → 1. slt same operands → 0.
